// File: rtl/core_prefetch.sv
// Instruction prefetch queue: issues sequential word fetches, buffers {word, pc}
// and presents the head to decode, substituting a NOP filler when empty.
module core_prefetch #(
  parameter int unsigned ORDER = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [29:0] target,
  output logic [29:0] addr,
  output logic        fetch,
  input  logic        fetched,
  input  logic [31:0] fetch_data,
  output logic [31:0] insn,
  output logic [29:0] insn_pc,
  output logic        nop
);

  localparam int unsigned Depth = 2 ** ORDER;
  localparam int unsigned PtrW  = ORDER + 1;
  localparam logic [31:0] NopInsn = 32'hE1A00000;

  logic [31:0]     word_q [Depth];
  logic [29:0]     pc_q   [Depth];
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PtrW-1:0] count_q, count_d;
  logic [29:0]     next_pc_q, next_pc_d;
  logic [29:0]     addr_q, addr_d;
  logic            fetch_q, fetch_d;
  logic            discard_q, discard_d;
  logic            ack, push, pop, hold_req;

  assign count_q  = tail_q - head_q;
  assign ack      = fetched & fetch_q;
  // A request that is up but unacknowledged can never be retracted.
  assign hold_req = fetch_q & ~fetched;
  assign push     = ack & ~discard_q & ~flush;
  assign pop      = ~flush & ~stall & (count_q != '0);

  always_comb begin
    tail_d    = tail_q + PtrW'(push);
    head_d    = flush ? tail_q : head_q + PtrW'(pop);
    count_d   = tail_d - head_d;
    next_pc_d = next_pc_q;
    if (flush) begin
      next_pc_d = target;
    end else if (push) begin
      next_pc_d = next_pc_q + 30'd1;
    end
    // A response still owed by the bus after a flush is stale and must be dropped.
    discard_d = hold_req & (flush | discard_q);
    fetch_d   = hold_req | (count_d < PtrW'(Depth));
    addr_d    = hold_req ? addr_q : next_pc_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      next_pc_q <= '0;
      addr_q    <= '0;
      fetch_q   <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      next_pc_q <= next_pc_d;
      addr_q    <= addr_d;
      fetch_q   <= fetch_d;
      discard_q <= discard_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      word_q[tail_q[ORDER-1:0]] <= fetch_data;
      pc_q[tail_q[ORDER-1:0]]   <= next_pc_q;
    end
  end

  always_comb begin
    nop     = (count_q == '0);
    insn    = nop ? NopInsn : word_q[head_q[ORDER-1:0]];
    insn_pc = pc_q[head_q[ORDER-1:0]];
    addr    = addr_q;
    fetch   = fetch_q;
  end

endmodule
